// File: rtl/wb_regfile.sv
// wb_regfile: eight-entry architectural register file at the end of the
// writeback stage. It provides two combinational read ports for decode and,
// once Halt arrives, drains the final register state over a valid/ready dump
// port, then raises Halted.
// Optional feature macro: RF_BYPASS_EN. When it is defined, a read of the
// register being written in the same cycle returns the incoming write data.
module wb_regfile #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic              WriteRegEn,
   input  logic              Halt,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              DumpValid,
   input  logic              DumpReady,
   output logic [ADDR_W-1:0] DumpReg,
   output logic [DATA_W-1:0] DumpData,
   output logic              Halted
);

   localparam int NumRegs = 1 << ADDR_W;

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] DUMP = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] dumpIdx;
   logic [DATA_W-1:0] regs [NumRegs];
   logic              lastIdx;
   logic              writeActive;

   assign lastIdx     = (dumpIdx == ADDR_W'(NumRegs - 1));
   assign writeActive = (state == RUN) && WriteRegEn;

   // Sequencer: RUN until Halt, then walk the dump index one handshake at a
   // time; the final transfer parks in DONE without wrapping the index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         dumpIdx <= '0;
      end else begin
         case (state)
            RUN: begin
               if (Halt) begin
                  state   <= DUMP;
                  dumpIdx <= '0;
               end
            end
            DUMP: begin
               if (DumpReady) begin
                  if (lastIdx) begin
                     state <= DONE;
                  end else begin
                     dumpIdx <= dumpIdx + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Register storage: commits only while running, so the dump sees a frozen
   // snapshot that includes a write issued alongside Halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs[i] <= '0;
         end
      end else if (writeActive) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Read ports: stored value, optionally overridden by a same-cycle write.
   always_comb begin
      ReadData1 = regs[ReadReg1];
      ReadData2 = regs[ReadReg2];
`ifdef RF_BYPASS_EN
      if (writeActive && (ReadReg1 == WriteReg)) begin
         ReadData1 = WriteData;
      end
      if (writeActive && (ReadReg2 == WriteReg)) begin
         ReadData2 = WriteData;
      end
`endif
   end

   // Dump outputs follow the registered index, so they hold while stalled.
   always_comb begin
      DumpValid = (state == DUMP);
      Halted    = (state == DONE);
      DumpReg   = dumpIdx;
      DumpData  = (state == DUMP) ? regs[dumpIdx] : '0;
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile. Uses a table of read /
// write vectors, randomized traffic against an array model of the register
// file, and directed dump, stall, done and mid-dump reset sequences.
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic [15:0] WriteData;
   logic [2:0]  WriteReg;
   logic        WriteRegEn;
   logic        Halt;
   logic [2:0]  ReadReg1;
   logic [2:0]  ReadReg2;
   logic [15:0] ReadData1;
   logic [15:0] ReadData2;
   logic        DumpValid;
   logic        DumpReady;
   logic [2:0]  DumpReg;
   logic [15:0] DumpData;
   logic        Halted;

   int testsRun;
   int testsFailed;

`ifdef RF_BYPASS_EN
   localparam bit BypassOn = 1'b1;
`else
   localparam bit BypassOn = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic [15:0] exp1;
      logic [15:0] exp2;
   } vec_t;

   vec_t        vecs [7];
   logic [15:0] mdl  [8];
   logic        readyPat [4];

   wb_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .WriteData  (WriteData),
      .WriteReg   (WriteReg),
      .WriteRegEn (WriteRegEn),
      .Halt       (Halt),
      .ReadReg1   (ReadReg1),
      .ReadReg2   (ReadReg2),
      .ReadData1  (ReadData1),
      .ReadData2  (ReadData2),
      .DumpValid  (DumpValid),
      .DumpReady  (DumpReady),
      .DumpReg    (DumpReg),
      .DumpData   (DumpData),
      .Halted     (Halted)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Expected read value from the architectural rules.
   function automatic logic [15:0] expRead(input logic [2:0] r, input logic [15:0] stored,
                                           input logic inRun, input logic we,
                                           input logic [2:0] wreg, input logic [15:0] wdata);
      return (BypassOn && inRun && we && (r == wreg)) ? wdata : stored;
   endfunction

   task automatic applyStimulus(input logic we, input logic [2:0] wreg, input logic [15:0] wdata,
                                input logic halt, input logic [2:0] r1, input logic [2:0] r2,
                                input logic rdy);
      WriteRegEn = we;
      WriteReg   = wreg;
      WriteData  = wdata;
      Halt       = halt;
      ReadReg1   = r1;
      ReadReg2   = r2;
      DumpReady  = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearModel();
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rstDumpValid", 32'(DumpValid), 32'd0);
      checkOutput("rstHalted", 32'(Halted), 32'd0);
      cycle();
      rst_n = 1'b1;
      clearModel();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      vecs[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b1, 3'd0, 16'h1234, 3'd0, 3'd5, 16'h0000, 16'hBEEF};
      vecs[3] = '{1'b1, 3'd3, 16'h00AA, 3'd0, 3'd3, 16'h1234, 16'h0000};
      vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'h00AA, 16'h1234};
      vecs[5] = '{1'b1, 3'd5, 16'h5555, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF};
      vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 16'h5555, 16'h0000};
      readyPat[0] = 1'b1;
      readyPat[1] = 1'b0;
      readyPat[2] = 1'b0;
      readyPat[3] = 1'b1;
      clearModel();

      // Reset state.
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetDumpValid", 32'(DumpValid), 32'd0);
      checkOutput("resetHalted", 32'(Halted), 32'd0);
      checkOutput("resetDumpReg", 32'(DumpReg), 32'd0);
      checkOutput("resetDumpData", 32'(DumpData), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'(i), 3'(7 - i), 1'b0);
         #1;
         checkOutput("resetRd1", 32'(ReadData1), 32'd0);
         checkOutput("resetRd2", 32'(ReadData2), 32'd0);
         cycle();
      end

      // Table-driven write / read vectors.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].we, vecs[i].wreg, vecs[i].wdata, 1'b0, vecs[i].r1, vecs[i].r2, 1'b0);
         #1;
         checkOutput("vecRd1", 32'(ReadData1),
                     32'(expRead(vecs[i].r1, vecs[i].exp1, 1'b1, vecs[i].we, vecs[i].wreg, vecs[i].wdata)));
         checkOutput("vecRd2", 32'(ReadData2),
                     32'(expRead(vecs[i].r2, vecs[i].exp2, 1'b1, vecs[i].we, vecs[i].wreg, vecs[i].wdata)));
         cycle();
         if (vecs[i].we) mdl[vecs[i].wreg] = vecs[i].wdata;
      end

      // Randomized traffic in RUN against the array model.
      for (int i = 0; i < 150; i++) begin
         logic        we;
         logic [2:0]  wreg, r1, r2;
         logic [15:0] wdata;
         we    = 1'($urandom_range(0, 1));
         wreg  = 3'($urandom_range(0, 7));
         wdata = 16'($urandom);
         r1    = 3'($urandom_range(0, 7));
         r2    = (i % 4 == 0) ? r1 : 3'($urandom_range(0, 7));
         applyStimulus(we, wreg, wdata, 1'b0, r1, r2, 1'($urandom_range(0, 1)));
         #1;
         checkOutput("randRd1", 32'(ReadData1), 32'(expRead(r1, mdl[r1], 1'b1, we, wreg, wdata)));
         checkOutput("randRd2", 32'(ReadData2), 32'(expRead(r2, mdl[r2], 1'b1, we, wreg, wdata)));
         checkOutput("randDumpValid", 32'(DumpValid), 32'd0);
         cycle();
         if (we) mdl[wreg] = wdata;
      end

      // Full-rate dump: Halt arrives with the r7 write.
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b1, 3'(n), 16'(16'h1000 + n), (n == 7), 3'd0, 3'd0, 1'b1);
         #1;
         checkOutput("fillDumpValid", 32'(DumpValid), 32'd0);
         cycle();
         mdl[n] = 16'(16'h1000 + n);
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd7, 3'd0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput("dumpValid", 32'(DumpValid), 32'd1);
         checkOutput("dumpReg", 32'(DumpReg), 32'(k));
         checkOutput("dumpData", 32'(DumpData), 32'(16'h1000 + k));
         checkOutput("dumpHaltedLow", 32'(Halted), 32'd0);
         cycle();
      end
      #1;
      checkOutput("doneHalted", 32'(Halted), 32'd1);
      checkOutput("doneDumpValid", 32'(DumpValid), 32'd0);

      // In DONE, Halt and writes are ignored.
      applyStimulus(1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 3'd1, 1'b1);
      #1;
      checkOutput("doneRdSame", 32'(ReadData1), 32'(expRead(3'd1, 16'h1001, 1'b0, 1'b1, 3'd1, 16'hFFFF)));
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd7, 1'b0);
      #1;
      checkOutput("doneHaltedHold", 32'(Halted), 32'd1);
      checkOutput("doneValidHold", 32'(DumpValid), 32'd0);
      checkOutput("doneR1Frozen", 32'(ReadData1), 32'h1001);
      checkOutput("doneR7Frozen", 32'(ReadData2), 32'h1007);

      // Stalled dump with writes attempted during DUMP.
      doReset();
      for (int n = 0; n < 8; n++) begin
         logic [15:0] v;
         v = 16'($urandom);
         applyStimulus(1'b1, 3'(n), v, 1'b0, 3'd0, 3'd0, 1'b0);
         cycle();
         mdl[n] = v;
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b0);
      cycle();
      begin
         int expIdx;
         expIdx = 0;
         for (int c = 0; c < 200 && expIdx < 8; c++) begin
            logic rdy;
            rdy = (c < 4) ? readyPat[c] : 1'($urandom_range(0, 1));
            applyStimulus(1'b1, 3'd2, 16'hFFFF, 1'b0, 3'd2, 3'(expIdx), rdy);
            #1;
            checkOutput("stallValid", 32'(DumpValid), 32'd1);
            checkOutput("stallReg", 32'(DumpReg), 32'(expIdx));
            checkOutput("stallData", 32'(DumpData), 32'(mdl[expIdx]));
            checkOutput("stallR2Frozen", 32'(ReadData1), 32'(mdl[2]));
            checkOutput("stallRdIdx", 32'(ReadData2), 32'(mdl[expIdx]));
            cycle();
            if (rdy) expIdx++;
         end
         checkOutput("stallBudget", 32'(expIdx), 32'd8);
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd0, 1'b0);
      #1;
      checkOutput("stallHalted", 32'(Halted), 32'd1);
      checkOutput("stallDoneValid", 32'(DumpValid), 32'd0);
      checkOutput("stallR2After", 32'(ReadData1), 32'(mdl[2]));

      // Reset in the middle of a dump.
      doReset();
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b1, 3'(n), 16'(16'h2000 + n), (n == 7), 3'd0, 3'd0, 1'b1);
         cycle();
         mdl[n] = 16'(16'h2000 + n);
      end
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd6, 1'b1);
         #1;
         checkOutput("midReg", 32'(DumpReg), 32'(k));
         checkOutput("midData", 32'(DumpData), 32'(mdl[k]));
         cycle();
      end
      #1;
      checkOutput("midPreValid", 32'(DumpValid), 32'd1);
      checkOutput("midPreReg", 32'(DumpReg), 32'd3);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", 32'(DumpValid), 32'd0);
      checkOutput("midRstHalted", 32'(Halted), 32'd0);
      checkOutput("midRstReg", 32'(DumpReg), 32'd0);
      for (int i = 0; i < 8; i++) begin
         ReadReg1 = 3'(i);
         ReadReg2 = 3'(7 - i);
         #1;
         checkOutput("midRstRd1", 32'(ReadData1), 32'd0);
         checkOutput("midRstRd2", 32'(ReadData2), 32'd0);
      end
      cycle();
      rst_n = 1'b1;
      clearModel();
      applyStimulus(1'b1, 3'd4, 16'hCAFE, 1'b0, 3'd4, 3'd1, 1'b1);
      #1;
      checkOutput("postRstSame", 32'(ReadData1), 32'(expRead(3'd4, 16'h0000, 1'b1, 1'b1, 3'd4, 16'hCAFE)));
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd1, 1'b1);
      #1;
      checkOutput("postRstRd1", 32'(ReadData1), 32'hCAFE);
      checkOutput("postRstRd2", 32'(ReadData2), 32'd0);
      checkOutput("postRstRun", 32'(DumpValid), 32'd0);
      cycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
